// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline stages.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush clears valid, load captures a new instruction,
// otherwise the contents are held.
module if_id_register
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pcplus4,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        valid
);

  // Flush wins over load; payload is left stale on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP_INSTR;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= next_instr;
      pcplus4 <= next_pcplus4;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory request FSM, stall hold
// buffer and the IF/ID pipeline register.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n, pc_plus4;
  logic [31:0]  holdbuf, holdbuf_n;
  logic [31:0]  ld_instr;
  logic         ld, fl;

  assign pc_plus4 = pc + PC_INC;

  // Moore request outputs: depend only on state and PC.
  assign ImemReq  = (state == REQ);
  assign ImemAddr = pc;

  // State, PC and hold-buffer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= BOOT;
      pc      <= word_align(RESET_PC);
      holdbuf <= NOP_INSTR;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      holdbuf <= holdbuf_n;
    end
  end

  // Next-state, PC update and IF/ID control; Redirect overrides everything.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    holdbuf_n = holdbuf;
    ld_instr  = ImemData;
    ld        = 1'b0;
    fl        = 1'b0;
    if (Redirect) begin
      pc_n      = word_align(RedirectPC);
      holdbuf_n = NOP_INSTR;
      fl        = 1'b1;
      state_n   = REQ;
    end else begin
      unique case (state)
        BOOT: state_n = REQ;
        REQ: begin
          if (ImemAck && !Stall) begin
            ld   = 1'b1;
            pc_n = pc_plus4;
          end else if (ImemAck && Stall) begin
            holdbuf_n = ImemData;
            state_n   = HOLD;
          end else if (!ImemAck && !Stall) begin
            fl = 1'b1;
          end
        end
        HOLD: begin
          if (!Stall) begin
            ld_instr = holdbuf;
            ld       = 1'b1;
            pc_n     = pc_plus4;
            state_n  = REQ;
          end
        end
        default: state_n = BOOT;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .load         (ld),
    .flush        (fl),
    .next_instr   (ld_instr),
    .next_pcplus4 (pc_plus4),
    .instr        (IfIdInstr),
    .pcplus4      (IfIdPCPlus4),
    .valid        (IfIdValid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus scoreboard of loads.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall, Redirect, ImemAck;
  logic [31:0] RedirectPC, ImemData;
  logic        ImemReq, IfIdValid;
  logic [31:0] ImemAddr, IfIdInstr, IfIdPCPlus4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        sb;
    logic [31:0] exp_pcp4;
    logic [31:0] exp_instr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } sb_t;

  sb_t  sbq[$];
  vec_t v[17];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemData    (ImemData),
    .IfIdInstr   (IfIdInstr),
    .IfIdPCPlus4 (IfIdPCPlus4),
    .IfIdValid   (IfIdValid)
  );

  always #5 Clk = ~Clk;

  // Memory content model: distinct word per address, nonzero at address 0.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h8C1F_0000;
  endfunction

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ak, input logic rq, input logic [31:0] ad,
                              input logic vl, input logic sb, input logic [31:0] p4,
                              input logic [31:0] ins);
    vec_t r;
    r.stall = st; r.redir = rd; r.rpc = rpc; r.ack = ak; r.exp_req = rq;
    r.exp_addr = ad; r.exp_valid = vl; r.sb = sb; r.exp_pcp4 = p4; r.exp_instr = ins;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ak, input logic [31:0] dat);
    Stall = st; Redirect = rd; RedirectPC = rpc; ImemAck = ak; ImemData = dat;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},   {31'd0, ImemReq}, 32'd0);
    chk({tag, "_addr"},  ImemAddr, 32'h0000_0000);
    chk({tag, "_instr"}, IfIdInstr, 32'd0);
    chk({tag, "_pcp4"},  IfIdPCPlus4, 32'd0);
    chk({tag, "_valid"}, {31'd0, IfIdValid}, 32'd0);
  endtask

  initial begin
    sb_t e;
    // stall redir rpc ack | req addr valid sb pcp4 instr
    v[0]  = mk(0, 0, 0,            1, 0, 32'h0,        0, 0, 32'h0,  32'h0);        // BOOT
    v[1]  = mk(0, 0, 0,            1, 1, 32'h0,        1, 1, 0, 0);
    v[2]  = mk(0, 0, 0,            1, 1, 32'h4,        1, 1, 0, 0);
    v[3]  = mk(0, 0, 0,            1, 1, 32'h8,        1, 1, 0, 0);
    v[4]  = mk(0, 0, 0,            1, 1, 32'hC,        1, 1, 0, 0);
    v[5]  = mk(1, 0, 0,            1, 1, 32'h10,       1, 0, 32'h10, mem(32'hC)); // ack+stall -> HOLD
    v[6]  = mk(1, 0, 0,            1, 0, 32'h10,       1, 0, 32'h10, mem(32'hC)); // HOLD, ack ignored
    v[7]  = mk(1, 0, 0,            0, 0, 32'h10,       1, 0, 32'h10, mem(32'hC));
    v[8]  = mk(0, 0, 0,            0, 0, 32'h10,       1, 1, 0, 0);                 // release: hold buffer
    v[9]  = mk(1, 1, 32'h0000_0403, 1, 1, 32'h14,      0, 0, 32'h14, mem(32'h10)); // redirect wins
    v[10] = mk(0, 0, 0,            0, 1, 32'h400,      0, 0, 32'h14, mem(32'h10)); // wait 1
    v[11] = mk(0, 0, 0,            0, 1, 32'h400,      0, 0, 32'h14, mem(32'h10)); // wait 2
    v[12] = mk(0, 0, 0,            1, 1, 32'h400,      1, 1, 0, 0);
    v[13] = mk(0, 1, 32'hFFFF_FFFC, 0, 1, 32'h404,     0, 0, 32'h404, mem(32'h400));
    v[14] = mk(0, 0, 0,            1, 1, 32'hFFFF_FFFC, 1, 1, 0, 0);              // wrap
    v[15] = mk(1, 0, 0,            0, 1, 32'h0,        1, 0, 32'h0, mem(32'hFFFF_FFFC));
    v[16] = mk(0, 0, 0,            1, 1, 32'h0,        1, 1, 0, 0);

    drive(0, 0, 0, 0, 0);
    Reset_n = 1'b0;
    #1;
    check_reset_values("reset");
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    for (int unsigned i = 0; i < 17; i++) begin
      drive(v[i].stall, v[i].redir, v[i].rpc, v[i].ack,
            v[i].exp_req ? mem(v[i].exp_addr) : 32'hDEAD_BEEF);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, ImemReq}, {31'd0, v[i].exp_req});
      chk($sformatf("v%0d_addr", i), ImemAddr, v[i].exp_addr);
      if (v[i].sb) begin
        e.instr = mem(v[i].exp_addr);
        e.pcp4  = v[i].exp_addr + 32'd4;
        sbq.push_back(e);
      end
      @(posedge Clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, IfIdValid}, {31'd0, v[i].exp_valid});
      if (v[i].sb) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL v%0d_sb: scoreboard empty", i);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("v%0d_instr", i), IfIdInstr, e.instr);
          chk($sformatf("v%0d_pcp4", i), IfIdPCPlus4, e.pcp4);
        end
      end else begin
        chk($sformatf("v%0d_instr", i), IfIdInstr, v[i].exp_instr);
        chk($sformatf("v%0d_pcp4", i), IfIdPCPlus4, v[i].exp_pcp4);
      end
    end

    // PC is now 4 in REQ: enter HOLD, then reset asynchronously mid-cycle.
    drive(1, 0, 0, 1, mem(32'h4));
    @(posedge Clk); #1;
    chk("hold_req", {31'd0, ImemReq}, 32'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge Clk); #1;
    drive(0, 1, 32'h0000_0081, 1, mem(32'h0));
    Reset_n = 1'b1;

    // Redirect while in BOOT: next state REQ at the aligned target.
    #1;
    chk("boot_req", {31'd0, ImemReq}, 32'd0);
    @(posedge Clk); #1;
    chk("boot_redir_valid", {31'd0, IfIdValid}, 32'd0);
    chk("boot_redir_req", {31'd0, ImemReq}, 32'd1);
    chk("boot_redir_addr", ImemAddr, 32'h0000_0080);
    drive(0, 0, 0, 1, mem(32'h80));
    e.instr = mem(32'h80);
    e.pcp4  = 32'h84;
    sbq.push_back(e);
    @(posedge Clk); #1;
    e = sbq.pop_front();
    chk("boot_redir_ld_valid", {31'd0, IfIdValid}, 32'd1);
    chk("boot_redir_ld_instr", IfIdInstr, e.instr);
    chk("boot_redir_ld_pcp4", IfIdPCPlus4, e.pcp4);
    chk("boot_redir_next_addr", ImemAddr, 32'h0000_0084);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, issues requests to instruction memory, and loads the IF/ID pipeline register. It consumes the single-bit redirect produced by the control-path OR gate (branch-taken OR jump) and the stall from the hazard unit. The instruction, PC+4 and a valid bit go to the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- Clk  input  1  rising-edge clock; only clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- Redirect  input  1  branch-taken OR jump; replace PC and flush.
- RedirectPC  input  32  target PC, valid while Redirect=1.
- ImemReq  output  1  instruction fetch request.
- ImemAddr  output  32  fetch address, equal to the PC.
- ImemAck  input  1  memory has returned data for the current ImemAddr this cycle.
- ImemData  input  32  instruction word, valid when ImemAck=1.
- IfIdInstr  output  32  registered instruction to decode.
- IfIdPCPlus4  output  32  registered address of fetched instruction + 4.
- IfIdValid  output  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- States: BOOT, REQ, HOLD. Reset enters BOOT.
- BOOT: ImemReq=0; next cycle goes to REQ unconditionally, unless Redirect=1, which loads the PC.
- REQ: ImemReq=1, ImemAddr=PC.
  - Ack=1, Stall=0: IF/ID <= {ImemData, PC+4, valid=1}; PC <= PC+4; stay in REQ.
  - Ack=1, Stall=1: ImemData is captured into the hold buffer; IF/ID frozen; go to HOLD.
  - Ack=0, Stall=0: IfIdValid <= 0 (bubble); PC unchanged.
  - Ack=0, Stall=1: IF/ID frozen.
- HOLD: ImemReq=0; IF/ID frozen while Stall=1.
  - On Stall=0: IF/ID <= {hold buffer, PC+4, valid=1}; PC <= PC+4; go to REQ.
- Redirect=1, in any state, takes priority over Stall and Ack:
  - PC <= {RedirectPC[31:2], 2'b00}; IfIdValid <= 0; hold buffer discarded.
  - Next state is REQ.
  - An ack arriving in the same cycle is dropped.
  - IfIdInstr and IfIdPCPlus4 may keep stale values when valid=0.
- Arithmetic:
  - PC+4 is 32-bit unsigned and wraps 32'hFFFF_FFFC -> 32'h0000_0000.
  - PC[1:0] is always 0; RESET_PC low bits are also forced to 0.
- Reset mid-request: abandons any outstanding fetch immediately. Memory must treat an ImemReq drop as a cancel.

## Timing
- Reset values:
  - PC=RESET_PC; IfIdInstr=0; IfIdPCPlus4=0; IfIdValid=0.
  - ImemReq=0; ImemAddr=RESET_PC; state=BOOT.
- ImemReq and ImemAddr are Moore outputs (from state and PC only). No combinational path from Stall or Redirect to them.
- Latency: data acked at edge N appears on IF/ID after edge N when Stall=0. With 1-cycle memory, throughput is one instruction per cycle.
- Request protocol:
  - ImemAddr is stable while ImemReq=1, except in the cycle following a Redirect.
  - Ack is sampled only when ImemReq=1.
- Redirect flush: IfIdValid is 0 for at least the cycle after the Redirect edge. The first target instruction appears at the earliest one memory latency later.

## Structure
- Shared package mips_pkg holds:
  - fetch state enum (BOOT, REQ, HOLD);
  - constant PC_INC = 4;
  - constant NOP_INSTR = 32'h0000_0000.
- One sub-module, if_id_register: the IF/ID register with load/hold/flush controls and async active-low reset.
- The FSM, PC and hold buffer stay in fetch_unit.

## Test plan
- Reset, then 1-cycle memory with Ack tied high: ImemReq=0 during BOOT. Addresses 0, 4, 8, … follow. IfIdPCPlus4 = 4, 8, 12 with IfIdValid=1 every cycle.
- Stall high for 3 cycles while Ack=1 at PC=0x10: enter HOLD with ImemReq=0 and IF/ID frozen. On release, IfIdInstr = captured word and PC becomes 0x14.
- Redirect=1 with RedirectPC=0x0000_0403 while Stall=1 and Ack=1: PC becomes 0x400, IfIdValid=0, and the acked word is not loaded.
- Memory with 3-cycle ack latency: IfIdValid=0 for the 2 wait cycles. ImemAddr stays constant until the ack.
- PC=0xFFFF_FFFC with an ack: IfIdPCPlus4=0 and the next ImemAddr=0.
- Reset_n asserted mid-request in HOLD: all outputs go to reset values immediately, asynchronously, before the next edge.
